// File: rtl/mmu_request_arbiter.sv
// Arbitrates the single MMU translation path between instruction fetch and data
// requesters: fixed data-over-fetch priority with a starvation guard and fetch flush discard.
module mmu_request_arbiter #(
  parameter int unsigned max_data_burst = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_fetch_vaild,
  input  logic [31:0] i_fetch_effective_address,
  input  logic        i_fetch_flush,
  output logic        o_fetch_ready,
  output logic [31:0] o_fetch_physical_address,
  input  logic        i_data_vaild,
  input  logic [2:0]  i_data_segment_index,
  input  logic [31:0] i_data_effective_address,
  input  logic        i_data_write_enable,
  output logic        o_data_ready,
  output logic [31:0] o_data_physical_address,
  output logic        o_mmu_vaild,
  output logic [2:0]  o_mmu_segment_index,
  output logic [31:0] o_mmu_effective_address,
  output logic        o_mmu_write_enable,
  input  logic        i_mmu_ready,
  input  logic [31:0] i_mmu_physical_address,
  output logic        o_busy,
  output logic        o_grant_fetch
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  localparam logic [2:0] BURST_LIMIT = 3'(max_data_burst);
  localparam logic [2:0] CS_INDEX    = 3'd1;

  state_t     r_state;
  logic [2:0] r_data_streak;
  logic       r_discard;

  logic w_fetch_eligible;
  logic w_grant_data;
  logic w_grant_fetch;
  logic w_fetch_flushed;

  always_comb begin
    w_fetch_eligible = i_fetch_vaild & ~i_fetch_flush;
    // A waiting fetch only overtakes data once the data streak has reached the burst limit.
    w_grant_data     = i_data_vaild & ~(w_fetch_eligible & (r_data_streak == BURST_LIMIT));
    w_grant_fetch    = w_fetch_eligible & ~w_grant_data;
    w_fetch_flushed  = o_grant_fetch & i_fetch_flush;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state                  <= ST_IDLE;
      r_data_streak            <= '0;
      r_discard                <= 1'b0;
      o_fetch_ready            <= 1'b0;
      o_fetch_physical_address <= '0;
      o_data_ready             <= 1'b0;
      o_data_physical_address  <= '0;
      o_mmu_vaild              <= 1'b0;
      o_mmu_segment_index      <= '0;
      o_mmu_effective_address  <= '0;
      o_mmu_write_enable       <= 1'b0;
      o_busy                   <= 1'b0;
      o_grant_fetch            <= 1'b0;
    end else begin
      o_mmu_vaild   <= 1'b0;
      o_fetch_ready <= 1'b0;
      o_data_ready  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_data | w_grant_fetch) begin
            r_state       <= ST_ISSUE;
            o_mmu_vaild   <= 1'b1;
            o_busy        <= 1'b1;
            o_grant_fetch <= w_grant_fetch;
            if (w_grant_fetch) begin
              o_mmu_segment_index     <= CS_INDEX;
              o_mmu_effective_address <= i_fetch_effective_address;
              o_mmu_write_enable      <= 1'b0;
              r_data_streak           <= '0;
            end else begin
              o_mmu_segment_index     <= i_data_segment_index;
              o_mmu_effective_address <= i_data_effective_address;
              o_mmu_write_enable      <= i_data_write_enable;
              // The streak only counts data grants that made a fetch wait.
              if (w_fetch_eligible && (r_data_streak != BURST_LIMIT))
                r_data_streak <= r_data_streak + 3'd1;
            end
          end
        end
        ST_ISSUE: begin
          // i_mmu_ready may still be high from the previous translation; ignore it here.
          if (w_fetch_flushed)
            r_discard <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_fetch_flushed)
            r_discard <= 1'b1;
          if (i_mmu_ready) begin
            r_state <= ST_RESPOND;
            if (!o_grant_fetch) begin
              o_data_physical_address <= i_mmu_physical_address;
              o_data_ready            <= 1'b1;
            end else if (!r_discard && !i_fetch_flush) begin
              o_fetch_physical_address <= i_mmu_physical_address;
              o_fetch_ready            <= 1'b1;
            end
          end
        end
        ST_RESPOND: begin
          r_discard <= 1'b0;
          o_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_request_arbiter.sv
// Directed self-checking bench for mmu_request_arbiter with a small latency-programmable MMU model.
module tb_mmu_request_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_fetch_vaild;
  logic [31:0] i_fetch_effective_address;
  logic        i_fetch_flush;
  logic        o_fetch_ready;
  logic [31:0] o_fetch_physical_address;
  logic        i_data_vaild;
  logic [2:0]  i_data_segment_index;
  logic [31:0] i_data_effective_address;
  logic        i_data_write_enable;
  logic        o_data_ready;
  logic [31:0] o_data_physical_address;
  logic        o_mmu_vaild;
  logic [2:0]  o_mmu_segment_index;
  logic [31:0] o_mmu_effective_address;
  logic        o_mmu_write_enable;
  logic        i_mmu_ready;
  logic [31:0] i_mmu_physical_address;
  logic        o_busy;
  logic        o_grant_fetch;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  int unsigned mmu_lat = 1;
  logic        mmu_pending;
  int unsigned mmu_cnt;

  mmu_request_arbiter #(.max_data_burst(4)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .i_fetch_vaild             (i_fetch_vaild),
    .i_fetch_effective_address (i_fetch_effective_address),
    .i_fetch_flush             (i_fetch_flush),
    .o_fetch_ready             (o_fetch_ready),
    .o_fetch_physical_address  (o_fetch_physical_address),
    .i_data_vaild              (i_data_vaild),
    .i_data_segment_index      (i_data_segment_index),
    .i_data_effective_address  (i_data_effective_address),
    .i_data_write_enable       (i_data_write_enable),
    .o_data_ready              (o_data_ready),
    .o_data_physical_address   (o_data_physical_address),
    .o_mmu_vaild               (o_mmu_vaild),
    .o_mmu_segment_index       (o_mmu_segment_index),
    .o_mmu_effective_address   (o_mmu_effective_address),
    .o_mmu_write_enable        (o_mmu_write_enable),
    .i_mmu_ready               (i_mmu_ready),
    .i_mmu_physical_address    (i_mmu_physical_address),
    .o_busy                    (o_busy),
    .o_grant_fetch             (o_grant_fetch)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // MMU model: clears ready on a request, raises it mmu_lat edges later, then holds it (stale) until the next request.
  // Translation is EA + 0x0001_0000.
  always @(posedge clock) begin
    if (reset) begin
      i_mmu_ready            <= 1'b0;
      i_mmu_physical_address <= '0;
      mmu_pending            <= 1'b0;
      mmu_cnt                <= 0;
    end else if (o_mmu_vaild) begin
      i_mmu_ready <= 1'b0;
      mmu_pending <= 1'b1;
      mmu_cnt     <= mmu_lat;
    end else if (mmu_pending) begin
      if (mmu_cnt <= 1) begin
        i_mmu_ready            <= 1'b1;
        i_mmu_physical_address <= o_mmu_effective_address + 32'h0001_0000;
        mmu_pending            <= 1'b0;
      end else begin
        mmu_cnt <= mmu_cnt - 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_mmu_vaild) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_fetch_ready || o_data_ready) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_fetch_ready, o_data_ready, o_mmu_vaild, o_busy, o_grant_fetch, o_mmu_write_enable} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {o_fetch_ready, o_data_ready, o_mmu_vaild, o_busy, o_grant_fetch, o_mmu_write_enable});
    end
    checks++;
    if ({o_fetch_physical_address, o_data_physical_address, o_mmu_effective_address, o_mmu_segment_index} !== '0) begin
      errors++;
      $display("FAIL reset_fields: got %h/%h/%h/%0d expected all zero",
               o_fetch_physical_address, o_data_physical_address, o_mmu_effective_address, o_mmu_segment_index);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_data();
    mmu_lat                  = 1;
    i_data_segment_index     = 3'd3;
    i_data_effective_address = 32'h0000_1234;
    i_data_write_enable      = 1'b0;
    i_data_vaild             = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      checks++;
      if (o_mmu_vaild !== (t == 1)) begin
        errors++;
        $display("FAIL single_mmu_vaild t=%0d: got %b expected %b", t, o_mmu_vaild, (t == 1));
      end
      checks++;
      if (o_data_ready !== (t == 4)) begin
        errors++;
        $display("FAIL single_data_ready t=%0d: got %b expected %b", t, o_data_ready, (t == 4));
      end
      checks++;
      if (o_fetch_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_fetch_ready t=%0d: got %b expected 0", t, o_fetch_ready);
      end
      checks++;
      if (o_busy !== (t <= 4)) begin
        errors++;
        $display("FAIL single_busy t=%0d: got %b expected %b", t, o_busy, (t <= 4));
      end
      if (t == 1) begin
        checks++;
        if (o_mmu_segment_index !== 3'd3 || o_mmu_effective_address !== 32'h0000_1234 || o_grant_fetch !== 1'b0) begin
          errors++;
          $display("FAIL single_request: got seg %0d ea %h gf %b expected seg 3 ea 00001234 gf 0",
                   o_mmu_segment_index, o_mmu_effective_address, o_grant_fetch);
        end
      end
      if (t == 4) begin
        checks++;
        if (o_data_physical_address !== 32'h0001_1234) begin
          errors++;
          $display("FAIL single_data_addr: got %h expected 00011234", o_data_physical_address);
        end
        i_data_vaild = 1'b0;
      end
    end
  endtask

  task automatic test_priority();
    int  exp_f[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit  seen;
    int  last_grant;
    do_reset();
    mmu_lat                   = 1;
    i_fetch_effective_address = 32'h0000_4000;
    i_data_segment_index      = 3'd3;
    i_data_effective_address  = 32'h0000_8000;
    i_data_write_enable       = 1'b1;
    i_fetch_vaild             = 1'b1;
    i_data_vaild              = 1'b1;
    last_grant                = 0;
    for (int k = 0; k < 10; k++) begin
      wait_grant(seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL prio_grant_timeout k=%0d: got no grant expected a grant", k);
        break;
      end
      if (k > 0) begin
        checks++;
        if (cycle - last_grant != 5) begin
          errors++;
          $display("FAIL prio_throughput k=%0d: got %0d cycles expected 5", k, cycle - last_grant);
        end
      end
      last_grant = cycle;
      checks++;
      if (o_grant_fetch !== exp_f[k][0]) begin
        errors++;
        $display("FAIL prio_order k=%0d: got grant_fetch %b expected %b", k, o_grant_fetch, exp_f[k][0]);
      end
      checks++;
      if (exp_f[k] == 1) begin
        if (o_mmu_segment_index !== 3'd1 || o_mmu_write_enable !== 1'b0 || o_mmu_effective_address !== 32'h0000_4000) begin
          errors++;
          $display("FAIL prio_fetch_fields k=%0d: got seg %0d we %b ea %h expected seg 1 we 0 ea 00004000",
                   k, o_mmu_segment_index, o_mmu_write_enable, o_mmu_effective_address);
        end
      end else begin
        if (o_mmu_segment_index !== 3'd3 || o_mmu_write_enable !== 1'b1 || o_mmu_effective_address !== 32'h0000_8000) begin
          errors++;
          $display("FAIL prio_data_fields k=%0d: got seg %0d we %b ea %h expected seg 3 we 1 ea 00008000",
                   k, o_mmu_segment_index, o_mmu_write_enable, o_mmu_effective_address);
        end
      end
      wait_ready(seen);
      checks++;
      if (!seen || o_fetch_ready !== exp_f[k][0] || o_data_ready !== !exp_f[k][0]) begin
        errors++;
        $display("FAIL prio_ready k=%0d: got fetch %b data %b expected fetch %b data %b",
                 k, o_fetch_ready, o_data_ready, exp_f[k][0], !exp_f[k][0]);
      end
      checks++;
      if (exp_f[k] == 1) begin
        if (o_fetch_physical_address !== 32'h0001_4000) begin
          errors++;
          $display("FAIL prio_fetch_addr k=%0d: got %h expected 00014000", k, o_fetch_physical_address);
        end
      end else begin
        if (o_data_physical_address !== 32'h0001_8000) begin
          errors++;
          $display("FAIL prio_data_addr k=%0d: got %h expected 00018000", k, o_data_physical_address);
        end
      end
    end
    i_fetch_vaild = 1'b0;
    i_data_vaild  = 1'b0;
    i_data_write_enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_flush();
    bit seen;
    int pulses;
    do_reset();
    // Flush during WAIT discards the 0x100 translation.
    mmu_lat                   = 3;
    i_fetch_effective_address = 32'h0000_0100;
    i_fetch_vaild             = 1'b1;
    wait_grant(seen);
    checks++;
    if (!seen || o_grant_fetch !== 1'b1 || o_mmu_effective_address !== 32'h0000_0100) begin
      errors++;
      $display("FAIL flush_first_grant: got seen %b gf %b ea %h expected 1 1 00000100",
               seen, o_grant_fetch, o_mmu_effective_address);
    end
    tick();
    i_fetch_flush             = 1'b1;
    i_fetch_effective_address = 32'h0000_0200;
    tick();
    i_fetch_flush = 1'b0;
    pulses = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_fetch_ready) pulses++;
      if (o_mmu_vaild) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL flush_no_pulse: got %0d fetch pulses expected 0", pulses);
    end
    checks++;
    if (!seen || o_grant_fetch !== 1'b1 || o_mmu_effective_address !== 32'h0000_0200) begin
      errors++;
      $display("FAIL flush_regrant: got seen %b gf %b ea %h expected 1 1 00000200",
               seen, o_grant_fetch, o_mmu_effective_address);
    end
    wait_ready(seen);
    checks++;
    if (!seen || o_fetch_ready !== 1'b1 || o_fetch_physical_address !== 32'h0001_0200) begin
      errors++;
      $display("FAIL flush_new_fetch: got ready %b addr %h expected 1 00010200", o_fetch_ready, o_fetch_physical_address);
    end
    // Flush in the same cycle as MMU ready suppresses the pulse.
    mmu_lat                   = 1;
    i_fetch_effective_address = 32'h0000_0300;
    wait_grant(seen);
    checks++;
    if (!seen || o_mmu_effective_address !== 32'h0000_0300) begin
      errors++;
      $display("FAIL flush_same_grant: got seen %b ea %h expected 1 00000300", seen, o_mmu_effective_address);
    end
    tick();
    tick();
    i_fetch_flush             = 1'b1;
    i_fetch_effective_address = 32'h0000_0400;
    tick();
    checks++;
    if (o_fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_cycle: got fetch_ready %b expected 0", o_fetch_ready);
    end
    i_fetch_flush = 1'b0;
    wait_grant(seen);
    checks++;
    if (!seen || o_mmu_effective_address !== 32'h0000_0400) begin
      errors++;
      $display("FAIL flush_same_regrant: got seen %b ea %h expected 1 00000400", seen, o_mmu_effective_address);
    end
    wait_ready(seen);
    checks++;
    if (!seen || o_fetch_ready !== 1'b1 || o_fetch_physical_address !== 32'h0001_0400) begin
      errors++;
      $display("FAIL flush_same_complete: got ready %b addr %h expected 1 00010400", o_fetch_ready, o_fetch_physical_address);
    end
    i_fetch_vaild = 1'b0;
    tick();
    // Flush does not affect a data transaction.
    i_data_segment_index     = 3'd3;
    i_data_effective_address = 32'h0000_0500;
    i_data_vaild             = 1'b1;
    wait_grant(seen);
    tick();
    i_fetch_flush = 1'b1;
    wait_ready(seen);
    checks++;
    if (!seen || o_data_ready !== 1'b1 || o_data_physical_address !== 32'h0001_0500) begin
      errors++;
      $display("FAIL flush_data_unaffected: got ready %b addr %h expected 1 00010500", o_data_ready, o_data_physical_address);
    end
    i_fetch_flush = 1'b0;
    i_data_vaild  = 1'b0;
    tick();
  endtask

  task automatic test_stale_ready();
    bit seen;
    do_reset();
    mmu_lat                  = 1;
    i_data_segment_index     = 3'd3;
    i_data_effective_address = 32'h0000_1000;
    i_data_vaild             = 1'b1;
    wait_grant(seen);
    wait_ready(seen);
    checks++;
    if (!seen || o_data_physical_address !== 32'h0001_1000) begin
      errors++;
      $display("FAIL stale_first: got ready %b addr %h expected 1 00011000", seen, o_data_physical_address);
    end
    i_data_vaild = 1'b0;
    tick();
    mmu_lat                  = 3;
    i_data_effective_address = 32'h0000_2000;
    i_data_vaild             = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      checks++;
      if (o_data_ready !== (t == 6)) begin
        errors++;
        $display("FAIL stale_ready t=%0d: got %b expected %b", t, o_data_ready, (t == 6));
      end
      if (t == 6) begin
        checks++;
        if (o_data_physical_address !== 32'h0001_2000) begin
          errors++;
          $display("FAIL stale_addr: got %h expected 00012000", o_data_physical_address);
        end
        i_data_vaild = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    int pulses;
    do_reset();
    mmu_lat                  = 5;
    i_data_segment_index     = 3'd3;
    i_data_effective_address = 32'h0000_3000;
    i_data_vaild             = 1'b1;
    wait_grant(seen);
    tick();
    reset   = 1'b1;
    mmu_lat = 1;
    tick();
    checks++;
    if ({o_fetch_ready, o_data_ready, o_mmu_vaild, o_busy, o_grant_fetch, o_mmu_write_enable} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_flags: got %b expected 000000",
               {o_fetch_ready, o_data_ready, o_mmu_vaild, o_busy, o_grant_fetch, o_mmu_write_enable});
    end
    checks++;
    if ({o_mmu_effective_address, o_mmu_segment_index, o_data_physical_address} !== '0) begin
      errors++;
      $display("FAIL midreset_fields: got ea %h seg %0d daddr %h expected all zero",
               o_mmu_effective_address, o_mmu_segment_index, o_data_physical_address);
    end
    reset  = 1'b0;
    pulses = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_data_ready) pulses++;
      if (o_mmu_vaild) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (pulses != 0 || !seen || o_mmu_effective_address !== 32'h0000_3000) begin
      errors++;
      $display("FAIL midreset_regrant: got pulses %0d seen %b ea %h expected 0 1 00003000",
               pulses, seen, o_mmu_effective_address);
    end
    wait_ready(seen);
    checks++;
    if (!seen || o_data_ready !== 1'b1 || o_data_physical_address !== 32'h0001_3000) begin
      errors++;
      $display("FAIL midreset_complete: got ready %b addr %h expected 1 00013000", o_data_ready, o_data_physical_address);
    end
    i_data_vaild = 1'b0;
    tick();
  endtask

  task automatic test_write_passthrough();
    bit seen;
    do_reset();
    mmu_lat                  = 2;
    i_data_segment_index     = 3'd2;
    i_data_effective_address = 32'hFFFF_FFFC;
    i_data_write_enable      = 1'b1;
    i_data_vaild             = 1'b1;
    wait_grant(seen);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (o_mmu_write_enable !== 1'b1 || o_mmu_segment_index !== 3'd2 ||
          o_mmu_effective_address !== 32'hFFFF_FFFC || o_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_fields t=%0d: got we %b seg %0d ea %h ready %b expected 1 2 fffffffc 0",
                 t, o_mmu_write_enable, o_mmu_segment_index, o_mmu_effective_address, o_data_ready);
      end
      tick();
    end
    // Ready arrives one cycle after the last field check above, so the pulse is already visible or next.
    if (!o_data_ready) wait_ready(seen);
    checks++;
    if (o_data_ready !== 1'b1 || o_data_physical_address !== 32'h0000_FFFC) begin
      errors++;
      $display("FAIL write_complete: got ready %b addr %h expected 1 0000fffc", o_data_ready, o_data_physical_address);
    end
    checks++;
    if (o_mmu_write_enable !== 1'b1 || o_mmu_segment_index !== 3'd2 || o_mmu_effective_address !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL write_hold: got we %b seg %0d ea %h expected 1 2 fffffffc",
               o_mmu_write_enable, o_mmu_segment_index, o_mmu_effective_address);
    end
    i_data_vaild        = 1'b0;
    i_data_write_enable = 1'b0;
    tick();
  endtask

  initial begin
    reset                     = 1'b1;
    i_fetch_vaild             = 1'b0;
    i_fetch_effective_address = '0;
    i_fetch_flush             = 1'b0;
    i_data_vaild              = 1'b0;
    i_data_segment_index      = '0;
    i_data_effective_address  = '0;
    i_data_write_enable       = 1'b0;
    test_reset();
    test_single_data();
    test_priority();
    test_flush();
    test_stale_ready();
    test_reset_mid();
    test_write_passthrough();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
